// File: rtl/load_store_sequencer.sv
// Control sequencer for load / load-immediate / store instructions.
// Moore FSM stepping T0..T7 with mem_ready waits bounded by TIMEOUT;
// every output is decoded from the registered state, wait counter and
// latched opcode only.
module load_store_sequencer #(
    parameter int OPC_W    = 5,
    parameter int ALU_W    = 4,
    parameter int ADD_CODE = 8,
    parameter int OP_LD    = 0,
    parameter int OP_LDI   = 1,
    parameter int OP_ST    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             IncPC,
    output logic             PCin,
    output logic             MARin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             read,
    output logic             write,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Grb,
    output logic             BAout,
    output logic             Yin,
    output logic             Cout,
    output logic             Rin,
    output logic             Rout,
    output logic [1:0]       mdr_read,
    output logic [ALU_W-1:0] alu_control,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [4:0]       state
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'd0,
        S_T0    = 5'd1,
        S_T1    = 5'd2,
        S_T2    = 5'd3,
        S_T3    = 5'd4,
        S_T4    = 5'd5,
        S_T5    = 5'd6,
        S_T6    = 5'd7,
        S_T7    = 5'd8,
        S_DONE  = 5'd9,
        S_FAULT = 5'd10
    } state_t;

    localparam logic [OPC_W-1:0] LD_C  = OPC_W'(OP_LD);
    localparam logic [OPC_W-1:0] LDI_C = OPC_W'(OP_LDI);
    localparam logic [OPC_W-1:0] ST_C  = OPC_W'(OP_ST);
    localparam logic [7:0]       TO_C  = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [7:0]       cnt_inc;
    logic             in_wait;

    assign cnt_inc = cnt_q + 8'd1;
    // States that stall on mem_ready: instruction fetch, ld data read, st write.
    assign in_wait = (state_q == S_T1) ||
                     ((state_q == S_T6) && (opc_q == LD_C)) ||
                     ((state_q == S_T7) && (opc_q == ST_C));
    assign state   = state_q;

    // State, wait counter and latched opcode registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
        end
    end

    // Next-state logic; the counter falls back to 0 on every move, so each
    // wait state is entered with a cleared count. Ready beats timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        opc_d   = opc_q;
        if (in_wait) begin
            if (mem_ready) begin
                case (state_q)
                    S_T1:    state_d = S_T2;
                    S_T6:    state_d = S_T7;
                    default: state_d = S_DONE;
                endcase
            end else if (cnt_inc == TO_C) begin
                state_d = S_FAULT;
            end else begin
                cnt_d = cnt_inc;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_T0;
                S_T0:    state_d = S_T1;
                S_T2:    state_d = S_T3;
                S_T3: begin
                    opc_d = opcode;
                    if (opcode == LD_C || opcode == LDI_C || opcode == ST_C)
                        state_d = S_T4;
                    else
                        state_d = S_FAULT;
                end
                S_T4:    state_d = S_T5;
                S_T5: begin
                    if (opc_q == LDI_C)
                        state_d = S_DONE;
                    else if (opc_q == LD_C || opc_q == ST_C)
                        state_d = S_T6;
                    else
                        state_d = S_FAULT;
                end
                S_T6:    state_d = (opc_q == ST_C) ? S_T7 : S_FAULT;
                S_T7:    state_d = (opc_q == LD_C) ? S_DONE : S_FAULT;
                S_DONE:  state_d = start ? S_T0 : S_IDLE;
                S_FAULT: if (start) state_d = S_T0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode; PCin/Zlowout in T1 only while the count is still 0.
    always_comb begin
        PCout       = 1'b0;
        IncPC       = 1'b0;
        PCin        = 1'b0;
        MARin       = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        IRin        = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        BAout       = 1'b0;
        Yin         = 1'b0;
        Cout        = 1'b0;
        Rin         = 1'b0;
        Rout        = 1'b0;
        mdr_read    = 2'b00;
        alu_control = '0;
        busy        = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                read = 1'b1; MDRin = 1'b1; mdr_read = 2'b01;
                if (cnt_q == 8'd0) begin
                    PCin = 1'b1; Zlowout = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end
            S_T4: begin
                Cout = 1'b1; Zin = 1'b1; alu_control = ALU_W'(ADD_CODE);
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (opc_q == LDI_C) begin
                    Gra = 1'b1; Rin = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                MDRin = 1'b1;
                if (opc_q == LD_C) begin
                    read = 1'b1; mdr_read = 2'b01;
                end else begin
                    Gra = 1'b1; Rout = 1'b1;
                end
            end
            S_T7: begin
                MDRout = 1'b1;
                if (opc_q == LD_C) begin
                    Gra = 1'b1; Rin = 1'b1;
                end else begin
                    write = 1'b1;
                end
            end
            S_DONE:  done  = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        busy = (state_q >= S_T0) && (state_q <= S_T7);
    end

endmodule
